// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: condition codes, FSM states,
// and the condition evaluation / flag-dependency helpers.
package branch_resolver_pkg;

  localparam logic [2:0] COND_EQ = 3'd0;
  localparam logic [2:0] COND_NE = 3'd1;
  localparam logic [2:0] COND_LT = 3'd2;
  localparam logic [2:0] COND_GE = 3'd3;
  localparam logic [2:0] COND_GT = 3'd4;
  localparam logic [2:0] COND_LE = 3'd5;
  localparam logic [2:0] COND_VS = 3'd6;
  localparam logic [2:0] COND_AL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Evaluate a condition code against the committed V/N/Z flags.
  function automatic logic cond_eval(input logic [2:0] cond, input logic v,
                                     input logic n, input logic z);
    logic lt;
    lt = n ^ v;
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_LT: cond_eval = lt;
      COND_GE: cond_eval = ~lt;
      COND_GT: cond_eval = ~z & ~lt;
      COND_LE: cond_eval = z | lt;
      COND_VS: cond_eval = v;
      default: cond_eval = 1'b1;
    endcase
  endfunction

  // True when the condition reads the Z flag.
  function automatic logic cond_needs_z(input logic [2:0] cond);
    case (cond)
      COND_EQ, COND_NE, COND_GT, COND_LE: cond_needs_z = 1'b1;
      default:                            cond_needs_z = 1'b0;
    endcase
  endfunction

  // True when the condition reads V and/or N.
  function automatic logic cond_needs_vn(input logic [2:0] cond);
    case (cond)
      COND_LT, COND_GE, COND_VS, COND_GT, COND_LE: cond_needs_vn = 1'b1;
      default:                                     cond_needs_vn = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolver_flag_pend_counter.sv
// Counts flag-writing instructions issued but not yet committed. Saturates
// at both ends instead of wrapping, and latches a sticky error when an
// increment at the maximum or a decrement at zero is attempted.
module flag_pend_counter #(
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              zero,
  output logic              err
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  // Issue adds one, commit removes one; both together leave the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (inc && !dec) begin
      if (cnt == CNT_MAX) err <= 1'b1;
      else                cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) err <= 1'b1;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/branch_resolver.sv
// Conditional-branch resolver: holds a branch from decode until every
// in-flight writer of the flags it reads has committed, then evaluates the
// condition and hands taken/target to fetch through a valid/ready handshake.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 16,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [OFF_W-1:0]  br_off,
  input  logic              iss_z,
  input  logic              iss_vn,
  input  logic              cmt_z,
  input  logic              cmt_vn,
  input  logic              V,
  input  logic              N,
  input  logic              Z,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic              stall,
  output logic              pend_err
);

  localparam int EXT_W = ADDR_W - OFF_W - 2;

  state_t             state, state_nxt;
  logic [2:0]         cond_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [OFF_W-1:0]   off_q;

  logic [PEND_W-1:0]  pend_z, pend_vn;
  logic               zero_z, zero_vn;
  logic               err_z, err_vn;
  logic               unused_cnt;

  logic               wait_clear;
  logic               taken_eval;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  byte_off;
  logic [ADDR_W-1:0]  target_eval;

  flag_pend_counter #(.PEND_W(PEND_W)) u_pend_z (
    .clk  (clk),
    .rst  (rst),
    .inc  (iss_z),
    .dec  (cmt_z),
    .cnt  (pend_z),
    .zero (zero_z),
    .err  (err_z)
  );

  flag_pend_counter #(.PEND_W(PEND_W)) u_pend_vn (
    .clk  (clk),
    .rst  (rst),
    .inc  (iss_vn),
    .dec  (cmt_vn),
    .cnt  (pend_vn),
    .zero (zero_vn),
    .err  (err_vn)
  );

  assign unused_cnt = ^{pend_z, pend_vn};
  assign pend_err   = err_z | err_vn;

  // Only the registered counts gate the wait, so a writer issued this same
  // cycle is younger than the branch and cannot hold it back.
  assign wait_clear = (zero_z  || !cond_needs_z(cond_q)) &&
                      (zero_vn || !cond_needs_vn(cond_q));

  assign taken_eval  = cond_eval(cond_q, V, N, Z);
  assign pc_plus4    = pc_q + ADDR_W'(4);
  assign byte_off    = {{EXT_W{off_q[OFF_W-1]}}, off_q, 2'b00};
  assign target_eval = taken_eval ? (pc_plus4 + byte_off) : pc_plus4;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept, wait for flags, present result.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (br_valid)   state_nxt = ST_WAIT;
      ST_WAIT: if (wait_clear) state_nxt = ST_RESP;
      ST_RESP: if (res_ready)  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request on accept and the result when the flags are settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_q     <= '0;
      pc_q       <= '0;
      off_q      <= '0;
      res_taken  <= 1'b0;
      res_target <= '0;
    end else begin
      if (state == ST_IDLE && br_valid) begin
        cond_q <= br_cond;
        pc_q   <= br_pc;
        off_q  <= br_off;
      end
      if (state == ST_WAIT && wait_clear) begin
        res_taken  <= taken_eval;
        res_target <= target_eval;
      end
    end
  end

  assign br_ready  = (state == ST_IDLE);
  assign stall     = (state == ST_WAIT);
  assign res_valid = (state == ST_RESP);

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver: a vector table covering
// every condition code and the address wrap, plus hand-written sequences for
// reset, flag dependency stalls, result hold-off and counter underflow.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic [31:0] br_pc;
  logic [15:0] br_off;
  logic        iss_z, iss_vn, cmt_z, cmt_vn;
  logic        V, N, Z;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic [31:0] res_target;
  logic        stall;
  logic        pend_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [2:0]  cond;
    logic        v, n, z;
    logic [31:0] pc;
    logic [15:0] off;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[$];

  branch_resolver #(.ADDR_W(32), .OFF_W(16), .PEND_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_cond    (br_cond),
    .br_pc      (br_pc),
    .br_off     (br_off),
    .iss_z      (iss_z),
    .iss_vn     (iss_vn),
    .cmt_z      (cmt_z),
    .cmt_vn     (cmt_vn),
    .V          (V),
    .N          (N),
    .Z          (Z),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_taken  (res_taken),
    .res_target (res_target),
    .stall      (stall),
    .pend_err   (pend_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Compare one value against its expected value and log a failure.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Present one branch and wait for its result; edges counts rising edges
  // from the accept edge up to the one after which res_valid is seen.
  task automatic applyStimulus(input logic [2:0] cond, input logic [31:0] pc,
                               input logic [15:0] off, input logic v,
                               input logic n, input logic z,
                               output int edges);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!br_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!br_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout: got br_ready=0, want 1 within 20 cycles");
    end
    br_valid = 1'b1;
    br_cond  = cond;
    br_pc    = pc;
    br_off   = off;
    V = v; N = n; Z = z;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    edges = 1;
    while (!res_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Let the handshake complete so the resolver is back in IDLE.
  task automatic finishResult();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;

    rst = 1'b1;
    br_valid = 1'b0; br_cond = '0; br_pc = '0; br_off = '0;
    iss_z = 1'b0; iss_vn = 1'b0; cmt_z = 1'b0; cmt_vn = 1'b0;
    V = 1'b0; N = 1'b0; Z = 1'b0;
    res_ready = 1'b1;

    vecs.push_back('{"eq_t",  3'd0, 0,0,1, 32'h0000_1000, 16'h0004, 1, 32'h0000_1014});
    vecs.push_back('{"eq_n",  3'd0, 0,0,0, 32'h0000_1000, 16'h0004, 0, 32'h0000_1004});
    vecs.push_back('{"ne_t",  3'd1, 0,0,0, 32'h0000_2000, 16'hFFFE, 1, 32'h0000_1FFC});
    vecs.push_back('{"lt_t",  3'd2, 0,1,0, 32'h0000_0300, 16'h0001, 1, 32'h0000_0308});
    vecs.push_back('{"lt_n",  3'd2, 1,1,0, 32'h0000_0300, 16'h0001, 0, 32'h0000_0304});
    vecs.push_back('{"ge_t",  3'd3, 0,0,0, 32'h0000_0400, 16'h0010, 1, 32'h0000_0444});
    vecs.push_back('{"ge_n",  3'd3, 1,0,0, 32'h0000_0400, 16'h0010, 0, 32'h0000_0404});
    vecs.push_back('{"gt_t",  3'd4, 1,1,0, 32'h0000_0500, 16'h0002, 1, 32'h0000_050C});
    vecs.push_back('{"gt_n",  3'd4, 0,0,1, 32'h0000_0500, 16'h0002, 0, 32'h0000_0504});
    vecs.push_back('{"le_t",  3'd5, 0,1,0, 32'h0000_0600, 16'h7FFF, 1, 32'h0002_0600});
    vecs.push_back('{"le_n",  3'd5, 1,1,0, 32'h0000_0600, 16'h7FFF, 0, 32'h0000_0604});
    vecs.push_back('{"vs_n",  3'd6, 0,1,1, 32'h0000_0700, 16'h0001, 0, 32'h0000_0704});
    vecs.push_back('{"vs_t",  3'd6, 1,0,0, 32'h0000_0700, 16'h0001, 1, 32'h0000_0708});
    vecs.push_back('{"al_t",  3'd7, 0,0,0, 32'h0000_0100, 16'h0003, 1, 32'h0000_0110});
    vecs.push_back('{"wrapt", 3'd3, 0,0,0, 32'hFFFF_FFFC, 16'hFFFF, 1, 32'hFFFF_FFFC});
    vecs.push_back('{"wrapn", 3'd2, 0,0,0, 32'hFFFF_FFFC, 16'hFFFF, 0, 32'h0000_0000});

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_br_ready",  32'(br_ready),  32'd1);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_taken",     32'(res_taken), 32'd0);
    checkOutput("rst_target",    res_target,     32'd0);
    checkOutput("rst_stall",     32'(stall),     32'd0);
    checkOutput("rst_pend_err",  32'(pend_err),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: counters idle, so every branch resolves at minimum latency.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cond, vecs[i].pc, vecs[i].off,
                    vecs[i].v, vecs[i].n, vecs[i].z, edges);
      checkOutput({vecs[i].name, "_lat"},    32'(edges),     32'd2);
      checkOutput({vecs[i].name, "_taken"},  32'(res_taken), 32'(vecs[i].exp_taken));
      checkOutput({vecs[i].name, "_target"}, res_target,     vecs[i].exp_target);
      finishResult();
    end

    // Two Z writers in flight: BEQ stalls until both have committed.
    @(negedge clk); iss_z = 1'b1;
    @(negedge clk); iss_z = 1'b1;
    @(negedge clk); iss_z = 1'b0;
    br_valid = 1'b1; br_cond = 3'd0; br_pc = 32'h0000_0800; br_off = 16'h0002;
    Z = 1'b1; V = 1'b0; N = 1'b0;
    @(posedge clk); #1;
    checkOutput("dep_stall0", 32'(stall), 32'd1);
    @(negedge clk); br_valid = 1'b0; cmt_z = 1'b1;
    @(posedge clk); #1;
    checkOutput("dep_stall1", 32'(stall),     32'd1);
    checkOutput("dep_valid1", 32'(res_valid), 32'd0);
    @(negedge clk); cmt_z = 1'b1;
    @(posedge clk); #1;
    checkOutput("dep_stall2", 32'(stall),     32'd1);
    checkOutput("dep_valid2", 32'(res_valid), 32'd0);
    @(negedge clk); cmt_z = 1'b0;
    @(posedge clk); #1;
    checkOutput("dep_valid3",  32'(res_valid), 32'd1);
    checkOutput("dep_stall3",  32'(stall),     32'd0);
    checkOutput("dep_taken",   32'(res_taken), 32'd1);
    checkOutput("dep_target",  res_target,     32'h0000_080C);
    checkOutput("dep_pend_err", 32'(pend_err), 32'd0);
    finishResult();

    // A pending Z writer does not block BLT, nor does a VN writer issued
    // while the branch sits in WAIT.
    @(negedge clk); iss_z = 1'b1;
    @(negedge clk); iss_z = 1'b0;
    br_valid = 1'b1; br_cond = 3'd2; br_pc = 32'h0000_0900; br_off = 16'h0001;
    N = 1'b1; V = 1'b0; Z = 1'b0;
    @(posedge clk); #1;
    br_valid = 1'b0; iss_vn = 1'b1;
    @(posedge clk); #1;
    iss_vn = 1'b0;
    checkOutput("young_valid",  32'(res_valid), 32'd1);
    checkOutput("young_taken",  32'(res_taken), 32'd1);
    checkOutput("young_target", res_target,     32'h0000_0908);
    finishResult();
    @(negedge clk); cmt_z = 1'b1; cmt_vn = 1'b1;
    @(negedge clk); cmt_z = 1'b0; cmt_vn = 1'b0;
    checkOutput("young_pend_err", 32'(pend_err), 32'd0);

    // Reset while waiting on two Z writers drops the request and counters.
    @(negedge clk); iss_z = 1'b1;
    @(negedge clk); iss_z = 1'b0;
    br_valid = 1'b1; br_cond = 3'd0; br_pc = 32'h0000_0A00; br_off = 16'h0001;
    Z = 1'b1;
    @(posedge clk); #1;
    br_valid = 1'b0; iss_z = 1'b1;
    @(posedge clk); #1;
    iss_z = 1'b0;
    checkOutput("mid_stall", 32'(stall), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1;
    checkOutput("mid_br_ready",  32'(br_ready),  32'd1);
    checkOutput("mid_res_valid", 32'(res_valid), 32'd0);
    checkOutput("mid_stall_off", 32'(stall),     32'd0);
    @(negedge clk); rst = 1'b0;
    applyStimulus(3'd0, 32'h0000_0B00, 16'h0001, 1'b0, 1'b0, 1'b1, edges);
    checkOutput("mid_cnt_clear_lat", 32'(edges),     32'd2);
    checkOutput("mid_cnt_clear_tgt", res_target,     32'h0000_0B08);
    checkOutput("mid_pend_err",      32'(pend_err),  32'd0);
    finishResult();

    // Result held while fetch back-pressures; VN commit with nothing pending
    // flags an underflow.
    res_ready = 1'b0;
    applyStimulus(3'd7, 32'h0000_0C00, 16'hFFF0, 1'b0, 1'b0, 1'b0, edges);
    checkOutput("hold_lat", 32'(edges), 32'd2);
    @(negedge clk); cmt_vn = 1'b1;
    @(negedge clk); cmt_vn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid",    32'(res_valid), 32'd1);
      checkOutput("hold_taken",    32'(res_taken), 32'd1);
      checkOutput("hold_target",   res_target,     32'h0000_0BC4);
      checkOutput("hold_br_ready", 32'(br_ready),  32'd0);
    end
    checkOutput("underflow_err", 32'(pend_err), 32'd1);
    finishResult();
    checkOutput("release_br_ready",  32'(br_ready),  32'd1);
    checkOutput("release_res_valid", 32'(res_valid), 32'd0);
    checkOutput("err_sticky",        32'(pend_err),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, want finish before 200000");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
